// File: rtl/fpu_result_uart_tx_if.sv
// Result strobe/data bundle between the FPU result producer and the UART transmitter.
interface fpu_result_uart_tx_if #(
    parameter int DATA_W = 16
);
    logic              result_valid;
    logic [DATA_W-1:0] result_data;

    modport master (output result_valid, output result_data);
    modport slave  (input  result_valid, input  result_data);
endinterface

// File: rtl/fpu_result_uart_tx.sv
// Buffers completed 16-bit FPU results in a small FIFO and sends each one as two
// 8N1 UART frames, low byte first.
module fpu_result_uart_tx #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    fpu_result_uart_tx_if.slave         res_if,
    input  logic [CNT_W-1:0]            clks_per_bit,
    input  logic                        overflow_clr,
    output logic                        tx_serial,
    output logic                        tx_busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]      ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0]    ONE_PTR  = AW'(1);
    localparam logic [CNT_W-1:0] ONE_BIT  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             state_q;
    logic               tx_q;
    logic               byte_sel_q;
    logic [2:0]         bit_idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   period_q;
    logic [DATA_W-1:0]  shadow_q;

    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic [7:0]         cur_byte_s;
    logic [CNT_W-1:0]   period_s;
    logic               bit_end_s;

    // FIFO next-state: a pop in the same cycle frees the slot a full-FIFO push needs
    always_comb begin
        pop_s      = (state_q == ST_IDLE) && (count_q != '0);
        push_s     = res_if.result_valid && ((count_q != FULL_CNT) || pop_s);
        drop_s     = res_if.result_valid && (count_q == FULL_CNT) && !pop_s;
        wr_ptr_d   = push_s ? (wr_ptr_q + ONE_PTR) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + ONE_PTR) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Bit-timing helpers for the FSM
    always_comb begin
        cur_byte_s = byte_sel_q ? shadow_q[15:8] : shadow_q[7:0];
        period_s   = (clks_per_bit == '0) ? ONE_BIT : clks_per_bit;
        bit_end_s  = (cnt_q == (period_q - ONE_BIT));
    end

    // FIFO pointer, occupancy and sticky overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= res_if.result_data;
        end
    end

    // Transmit FSM; tx_q is loaded with the level of the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_q       <= 1'b1;
            byte_sel_q <= 1'b0;
            bit_idx_q  <= 3'd0;
            cnt_q      <= '0;
            period_q   <= ONE_BIT;
            shadow_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        shadow_q   <= mem_q[rd_ptr_q];
                        byte_sel_q <= 1'b0;
                        cnt_q      <= '0;
                        period_q   <= period_s;
                        tx_q       <= 1'b0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        tx_q      <= cur_byte_s[0];
                        state_q   <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + ONE_BIT;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= cur_byte_s[bit_idx_q + 3'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE_BIT;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        cnt_q <= '0;
                        if (!byte_sel_q) begin
                            // High byte follows immediately, with a freshly latched period
                            byte_sel_q <= 1'b1;
                            period_q   <= period_s;
                            tx_q       <= 1'b0;
                            state_q    <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE_BIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign tx_serial  = tx_q;
    assign tx_busy    = (state_q != ST_IDLE) || (count_q != '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed + randomized bench: an independent UART receiver decodes the line and the
// decoded bytes are compared against the byte stream expected from the pushed results.
module tb_fpu_result_uart_tx;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] clks_per_bit = 16'd4;
    logic             overflow_clr = 1'b0;
    logic             tx_serial, tx_busy, fifo_full, overflow;
    logic [2:0]       fifo_count;

    fpu_result_uart_tx_if #(.DATA_W(16)) res_if ();

    fpu_result_uart_tx #(.DATA_W(16), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .res_if       (res_if),
        .clks_per_bit (clks_per_bit),
        .overflow_clr (overflow_clr),
        .tx_serial    (tx_serial),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rx_p     = 4;
    int rx_gen   = 0;
    int push_cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         rx_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: each accepted result appears on the line as low byte then high byte
    task automatic expect_result(input logic [15:0] d);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
    endtask

    task automatic push(input logic [15:0] d);
        res_if.result_valid = 1'b1;
        res_if.result_data  = d;
        push_cyc = cyc;
        @(posedge clk); #1;
        res_if.result_valid = 1'b0;
    endtask

    task automatic wait_low(output int s);
        bit found = 1'b0;
        s = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                found = 1'b1;
                s = cyc;
            end
        end
        check("start_bit_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_idle(output int t);
        bit found = 1'b0;
        t = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) begin
                found = 1'b1;
                t = cyc;
            end
        end
        check("busy_falls", {31'd0, found}, 32'd1);
    endtask

    task automatic compare_bytes(input string tag);
        int n;
        check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
        rx_t.delete();
    endtask

    // Line receiver: samples each bit mid-period using the period announced at frame start
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (!rst && tx_serial === 1'b0) begin
                int p, cur, tgt, g;
                logic [9:0] fr;
                p   = (rx_p == 0) ? 1 : rx_p;
                g   = rx_gen;
                cur = 0;
                rx_t.push_back(cyc);
                for (int k = 0; k < 10; k++) begin
                    tgt = k * p + (p - 1) / 2;
                    repeat (tgt - cur) @(negedge clk);
                    cur = tgt;
                    fr[k] = tx_serial;
                end
                repeat (10 * p - 1 - cur) @(negedge clk);
                if (g == rx_gen) begin
                    check("rx_start_level", {31'd0, fr[0]}, 32'd0);
                    check("rx_stop_level", {31'd0, fr[9]}, 32'd1);
                    rx_q.push_back(fr[8:1]);
                end else begin
                    void'(rx_t.pop_back());
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s, t, n;
        logic [15:0] d, a;
        logic [15:0] b [6];
        res_if.result_valid = 1'b0;
        res_if.result_data  = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, tx_serial}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Single result 0x3C00 at 4 clocks per bit
        @(posedge clk); #1;
        clks_per_bit = 16'd4; rx_p = 4;
        push(16'h3C00); expect_result(16'h3C00);
        n = push_cyc;
        wait_idle(t);
        check("t1_latency", rx_t[0], n + 2);
        check("t1_frame_len", rx_t[1] - rx_t[0], 32'd40);
        check("t1_busy_fall", t - rx_t[0], 32'd80);
        compare_bytes("t1");

        // Two results in consecutive cycles
        repeat (5) @(posedge clk); #1;
        push(16'hC500); expect_result(16'hC500);
        push(16'h7BFF); expect_result(16'h7BFF);
        wait_idle(t);
        check("t2_frame_gap", rx_t[1] - rx_t[0], 32'd40);
        check("t2_result_gap", rx_t[2] - rx_t[0], 32'd81);
        compare_bytes("t2");

        // Overflow while the line is busy
        repeat (5) @(posedge clk); #1;
        a = 16'hA55A;
        push(a); expect_result(a);
        wait_low(s);
        for (int i = 0; i < 6; i++) begin
            b[i] = 16'h1000 + 16'(i * 16'h0111);
            push(b[i]);
            if (i < 4) expect_result(b[i]);
        end
        @(negedge clk);
        check("t3_count", {29'd0, fifo_count}, 32'd4);
        check("t3_full", {31'd0, fifo_full}, 32'd1);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        overflow_clr = 1'b1;
        push(16'hDEAD);
        overflow_clr = 1'b0;
        @(negedge clk);
        check("t3_ovf_clr_vs_drop", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1;
        overflow_clr = 1'b1;
        @(posedge clk); #1;
        overflow_clr = 1'b0;
        @(negedge clk);
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);
        wait_idle(t);
        compare_bytes("t3");

        // Reset during the high byte's data bits
        repeat (5) @(posedge clk); #1;
        push(16'h1234);
        wait_low(s);
        push(16'h5678);
        while (cyc < s + 50) begin @(posedge clk); #1; end
        rx_gen++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t4_tx_after_rst", {31'd0, tx_serial}, 32'd1);
        check("t4_count_after_rst", {29'd0, fifo_count}, 32'd0);
        check("t4_busy_after_rst", {31'd0, tx_busy}, 32'd0);
        check("t4_full_after_rst", {31'd0, fifo_full}, 32'd0);
        repeat (50) @(posedge clk); #1;
        exp_q.push_back(8'h34);
        compare_bytes("t4_pre");
        push(16'h0001); expect_result(16'h0001);
        wait_idle(t);
        compare_bytes("t4_post");

        // Period change mid-frame applies from the next frame
        repeat (5) @(posedge clk); #1;
        clks_per_bit = 16'd4; rx_p = 4;
        push(16'h96E1); expect_result(16'h96E1);
        wait_low(s);
        repeat (10) @(posedge clk); #1;
        clks_per_bit = 16'd8; rx_p = 8;
        wait_idle(t);
        check("t5_low_frame_len", rx_t[1] - rx_t[0], 32'd40);
        check("t5_busy_fall", t - s, 32'd120);
        compare_bytes("t5");

        // Zero period -> 1-cycle bits; push coinciding with a pop while full
        repeat (5) @(posedge clk); #1;
        clks_per_bit = 16'd0; rx_p = 0;
        push(16'h0F0F); expect_result(16'h0F0F);
        wait_low(s);
        for (int i = 0; i < 4; i++) begin
            d = 16'h2000 + 16'(i * 16'h0303);
            push(d); expect_result(d);
        end
        while (cyc < s + 20) begin @(posedge clk); #1; end
        check("t6_full_before", {31'd0, fifo_full}, 32'd1);
        push(16'hBEEF); expect_result(16'hBEEF);
        @(negedge clk);
        check("t6_count_same", {29'd0, fifo_count}, 32'd4);
        check("t6_no_ovf", {31'd0, overflow}, 32'd0);
        wait_idle(t);
        check("t6_frame_len", rx_t[1] - rx_t[0], 32'd10);
        compare_bytes("t6");

        // Randomized results and periods
        for (int it = 0; it < 6; it++) begin
            repeat (5) @(posedge clk); #1;
            clks_per_bit = 16'($urandom_range(0, 5));
            rx_p = int'(clks_per_bit);
            n = $urandom_range(1, 2);
            for (int j = 0; j < n; j++) begin
                d = 16'($urandom);
                push(d); expect_result(d);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            wait_idle(t);
            check("rnd_no_ovf", {31'd0, overflow}, 32'd0);
            compare_bytes("rnd");
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
